// File: rtl/addr_reg_pkg.sv
// rtl/addr_reg_pkg.sv - FunSel encodings and register index constants for addr_reg_bank
package addr_reg_pkg;

   typedef enum logic [1:0] {
      FUN_DEC  = 2'b00,
      FUN_INC  = 2'b01,
      FUN_LOAD = 2'b10,
      FUN_CLR  = 2'b11
   } fun_sel_e;

   localparam int IDX_PC  = 0;
   localparam int IDX_SP  = 1;
   localparam int IDX_AR0 = 2;

endpackage

// File: rtl/addr_reg_cell.sv
// rtl/addr_reg_cell.sv - one address register with enable, function select and hold override
module addr_reg_cell
   import addr_reg_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  fun_sel_e         fun,
   input  logic             hold,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // apply the selected operation when enabled; hold freezes the value even if enabled
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RESET_VAL;
      end else if (en && !hold) begin
         case (fun)
            FUN_DEC:  q <= q - 1'b1;
            FUN_INC:  q <= q + 1'b1;
            FUN_LOAD: q <= d;
            FUN_CLR:  q <= '0;
            default:  q <= q;
         endcase
      end
   end

endmodule

// File: rtl/addr_reg_bank.sv
// rtl/addr_reg_bank.sv - PC/SP/AR register bank with PC shadow, dual read ports, optional SP bounds check (ADDR_REG_BANK_STACK_CHECK_EN)
module addr_reg_bank
   import addr_reg_pkg::*;
#(
   parameter int               WIDTH      = 16,
   parameter int               NREG       = 4,
   parameter int               SELW       = $clog2(NREG),
   parameter logic [WIDTH-1:0] RESET_PC   = '0,
   parameter logic [WIDTH-1:0] STACK_TOP  = 16'hFFFF,
   parameter logic [WIDTH-1:0] STACK_BASE = 16'hFF00
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] I,
   input  logic [NREG-1:0]  RegSel,
   input  logic [1:0]       FunSel,
   input  logic [SELW-1:0]  OutCSel,
   input  logic [SELW-1:0]  OutDSel,
   input  logic             Snapshot,
   input  logic             Restore,
   input  logic             ClrFlags,
   output logic [WIDTH-1:0] OutC,
   output logic [WIDTH-1:0] OutD,
   output logic             SpOvf,
   output logic             SpUnf
);

   logic [WIDTH-1:0] regs [NREG];
   logic [WIDTH-1:0] shadow;
   logic             sp_hold;

   for (genvar k = 0; k < NREG; k++) begin : g_reg
      localparam logic [WIDTH-1:0] RV = (k == IDX_PC) ? RESET_PC :
                                        (k == IDX_SP) ? STACK_TOP : '0;
      logic             en;
      fun_sel_e         fun;
      logic [WIDTH-1:0] d;
      logic             hold;

      if (k == IDX_PC) begin : g_pc
         // Restore forces a load from the shadow, overriding whatever RegSel[0] asked for
         assign en   = RegSel[k] | Restore;
         assign fun  = Restore ? FUN_LOAD : fun_sel_e'(FunSel);
         assign d    = Restore ? shadow : I;
         assign hold = 1'b0;
      end else begin : g_other
         assign en   = RegSel[k];
         assign fun  = fun_sel_e'(FunSel);
         assign d    = I;
         assign hold = (k == IDX_SP) ? sp_hold : 1'b0;
      end

      addr_reg_cell #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RV)
      ) u_cell (
         .clk   (Clock),
         .reset (Reset),
         .en    (en),
         .fun   (fun),
         .hold  (hold),
         .d     (d),
         .q     (regs[k])
      );
   end

   // shadow samples the pre-edge PC, so Snapshot with Restore swaps PC and shadow
   always_ff @(posedge Clock) begin
      if (Reset) begin
         shadow <= RESET_PC;
      end else if (Snapshot) begin
         shadow <= regs[IDX_PC];
      end
   end

`ifdef ADDR_REG_BANK_STACK_CHECK_EN
   logic dec_fault;
   logic inc_fault;

   // stack grows down: decrementing past the base overflows, incrementing past the top underflows
   assign dec_fault = RegSel[IDX_SP] && (FunSel == FUN_DEC) && (regs[IDX_SP] == STACK_BASE);
   assign inc_fault = RegSel[IDX_SP] && (FunSel == FUN_INC) && (regs[IDX_SP] == STACK_TOP);
   assign sp_hold   = dec_fault | inc_fault;

   // sticky flags; a new fault beats a simultaneous clear
   always_ff @(posedge Clock) begin
      if (Reset) begin
         SpOvf <= 1'b0;
         SpUnf <= 1'b0;
      end else begin
         if (dec_fault)     SpOvf <= 1'b1;
         else if (ClrFlags) SpOvf <= 1'b0;
         if (inc_fault)     SpUnf <= 1'b1;
         else if (ClrFlags) SpUnf <= 1'b0;
      end
   end
`else
   localparam logic [WIDTH-1:0] unused_stack_base = STACK_BASE;
   logic unused_clr_flags;

   assign unused_clr_flags = ClrFlags;
   assign sp_hold          = 1'b0;
   assign SpOvf            = 1'b0;
   assign SpUnf            = 1'b0;
`endif

   // read ports: out-of-range selects read the last register
   always_comb begin
      OutC = regs[NREG-1];
      OutD = regs[NREG-1];
      for (int k = 0; k < NREG; k++) begin
         if (int'(OutCSel) == k) OutC = regs[k];
         if (int'(OutDSel) == k) OutD = regs[k];
      end
   end

endmodule

// File: tb/tb_addr_reg_bank.sv
// tb/tb_addr_reg_bank.sv - scoreboard bench for addr_reg_bank
module tb_addr_reg_bank;

   localparam int WIDTH = 16;
   localparam int NREG  = 4;
   localparam int SELW  = 2;

   logic             Clock = 1'b0;
   logic             Reset;
   logic [WIDTH-1:0] I;
   logic [NREG-1:0]  RegSel;
   logic [1:0]       FunSel;
   logic [SELW-1:0]  OutCSel;
   logic [SELW-1:0]  OutDSel;
   logic             Snapshot;
   logic             Restore;
   logic             ClrFlags;
   logic [WIDTH-1:0] OutC;
   logic [WIDTH-1:0] OutD;
   logic             SpOvf;
   logic             SpUnf;

   addr_reg_bank #(
      .WIDTH (WIDTH),
      .NREG  (NREG)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .I        (I),
      .RegSel   (RegSel),
      .FunSel   (FunSel),
      .OutCSel  (OutCSel),
      .OutDSel  (OutDSel),
      .Snapshot (Snapshot),
      .Restore  (Restore),
      .ClrFlags (ClrFlags),
      .OutC     (OutC),
      .OutD     (OutD),
      .SpOvf    (SpOvf),
      .SpUnf    (SpUnf)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      string            tag;
      logic [WIDTH-1:0] c;
      logic [WIDTH-1:0] d;
      logic             ovf;
      logic             unf;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [1:0] DEC = 2'b00, INC = 2'b01, LD = 2'b10, CLR = 2'b11;

`ifdef ADDR_REG_BANK_STACK_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   task automatic cmp(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // monitor: compare every pending expectation against the outputs at the falling edge
   always @(negedge Clock) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         cmp({e.tag, ".c"},   OutC, e.c);
         cmp({e.tag, ".d"},   OutD, e.d);
         cmp({e.tag, ".ovf"}, {15'd0, SpOvf}, {15'd0, e.ovf});
         cmp({e.tag, ".unf"}, {15'd0, SpUnf}, {15'd0, e.unf});
      end
   end

   task automatic op(input logic [NREG-1:0] rs, input logic [1:0] fs, input logic [WIDTH-1:0] data,
                     input logic snap = 0, input logic rest = 0, input logic clr = 0, input logic rst = 0);
      RegSel = rs; FunSel = fs; I = data;
      Snapshot = snap; Restore = rest; ClrFlags = clr; Reset = rst;
      @(posedge Clock); #1;
      RegSel = '0; FunSel = INC; I = '0;
      Snapshot = 0; Restore = 0; ClrFlags = 0; Reset = 0;
   endtask

   task automatic expect_out(input string tag, input logic [SELW-1:0] cs, input logic [SELW-1:0] ds,
                             input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                             input logic ovf, input logic unf);
      exp_t e;
      OutCSel = cs; OutDSel = ds;
      e.tag = tag; e.c = c; e.d = d; e.ovf = ovf; e.unf = unf;
      exp_q.push_back(e);
      @(negedge Clock); #1;
   endtask

   initial begin
      RegSel = '0; FunSel = INC; I = '0; Snapshot = 0; Restore = 0; ClrFlags = 0;
      OutCSel = '0; OutDSel = '0; Reset = 1;
      repeat (2) @(posedge Clock);
      #1 Reset = 0;

      expect_out("reset", 2'd0, 2'd1, 16'h0000, 16'hFFFF, 0, 0);

      // counting on PC and AR0 together
      op(4'b0001, LD, 16'h1234);
      repeat (3) op(4'b0101, INC, '0);
      expect_out("count", 2'd0, 2'd2, 16'h1237, 16'h0003, 0, 0);

      // PC wrap, SP untouched
      op(4'b0001, LD, 16'hFFFF);
      op(4'b0001, INC, '0);
      expect_out("pc_wrap", 2'd0, 2'd1, 16'h0000, 16'hFFFF, 0, 0);

      // select 7 truncated to 2 bits selects AR1, same as select 3
      op(4'b1000, LD, 16'hABCD);
      expect_out("ar1_dual", 2'd3, SELW'(7), 16'hABCD, 16'hABCD, 0, 0);

      // SP decrement down to and past the base
      op(4'b0010, LD, 16'hFF01);
      op(4'b0010, DEC, '0);
      expect_out("sp_dec1", 2'd1, 2'd1, 16'hFF00, 16'hFF00, 0, 0);
      op(4'b0010, DEC, '0);
      expect_out("sp_dec2", 2'd1, 2'd0, CHK ? 16'hFF00 : 16'hFEFF, 16'h0000, CHK, 0);
      op(4'b0000, INC, '0);
      expect_out("ovf_sticky", 2'd1, 2'd1, CHK ? 16'hFF00 : 16'hFEFF, CHK ? 16'hFF00 : 16'hFEFF, CHK, 0);
      op(4'b0000, INC, '0, 0, 0, 1);
      expect_out("ovf_clr", 2'd1, 2'd1, CHK ? 16'hFF00 : 16'hFEFF, CHK ? 16'hFF00 : 16'hFEFF, 0, 0);
      op(4'b0010, DEC, '0, 0, 0, 1);
      expect_out("ovf_vs_clr", 2'd1, 2'd1, CHK ? 16'hFF00 : 16'hFEFE, CHK ? 16'hFF00 : 16'hFEFE, CHK, 0);
      op(4'b0000, INC, '0, 0, 0, 1);

      // SP increment at the top
      op(4'b0010, LD, 16'hFFFF);
      op(4'b0010, INC, '0);
      expect_out("sp_inc_top", 2'd1, 2'd1, CHK ? 16'hFFFF : 16'h0000, CHK ? 16'hFFFF : 16'h0000, 0, CHK);
      op(4'b0000, INC, '0, 0, 0, 1);
      expect_out("unf_clr", 2'd1, 2'd1, CHK ? 16'hFFFF : 16'h0000, CHK ? 16'hFFFF : 16'h0000, 0, 0);

      // snapshot then restore beating a simultaneous increment
      op(4'b0001, LD, 16'h0040);
      op(4'b0000, INC, '0, 1, 0);
      op(4'b0001, LD, 16'h0100);
      expect_out("pc_loaded", 2'd0, 2'd0, 16'h0100, 16'h0100, 0, 0);
      op(4'b0001, INC, '0, 0, 1);
      expect_out("restore", 2'd0, 2'd0, 16'h0040, 16'h0040, 0, 0);

      // snapshot and restore together swap PC and shadow
      op(4'b0001, LD, 16'h0010);
      op(4'b0000, INC, '0, 1, 1);
      expect_out("swap_pc", 2'd0, 2'd0, 16'h0040, 16'h0040, 0, 0);
      op(4'b0000, INC, '0, 0, 1);
      expect_out("swap_shadow", 2'd0, 2'd0, 16'h0010, 16'h0010, 0, 0);

      // reset wins over a pending increment on every register
      op(4'b1111, INC, '0, 0, 0, 0, 1);
      expect_out("rst_pc_sp", 2'd0, 2'd1, 16'h0000, 16'hFFFF, 0, 0);
      expect_out("rst_ar", 2'd2, 2'd3, 16'h0000, 16'h0000, 0, 0);
      op(4'b0001, LD, 16'h0005);
      op(4'b0000, INC, '0, 0, 1);
      expect_out("rst_shadow", 2'd0, 2'd0, 16'h0000, 16'h0000, 0, 0);

      for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge Clock);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
